// File: rtl/regfile_wbck.sv
// Write-back arbiter and long-latency scoreboard for the integer register file.
// Optional operand forwarding from the in-flight write is enabled by defining WBCK_BYPASS_EN.

`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module regfile_wbck #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      i_alu_valid,
    output logic                      o_alu_ready,
    input  logic [`RFIDX_WIDTH-1:0]   i_alu_rdidx,
    input  logic [31:0]               i_alu_rd,

    input  logic                      i_long_valid,
    output logic                      o_long_ready,
    input  logic [`RFIDX_WIDTH-1:0]   i_long_rdidx,
    input  logic [31:0]               i_long_rd,

    output logic                      o_rden,
    output logic [`RFIDX_WIDTH-1:0]   o_rdidx,
    output logic [31:0]               o_rd,

    input  logic                      i_disp_valid,
    input  logic                      i_disp_long,
    input  logic [`RFIDX_WIDTH-1:0]   i_disp_rdidx,

    input  logic                      i_chk_rs1en,
    input  logic                      i_chk_rs2en,
    input  logic                      i_chk_rden,
    input  logic [`RFIDX_WIDTH-1:0]   i_chk_rs1idx,
    input  logic [`RFIDX_WIDTH-1:0]   i_chk_rs2idx,
    input  logic [`RFIDX_WIDTH-1:0]   i_chk_rdidx,
    output logic                      o_stall,

    input  logic [31:0]               i_rf_rs1,
    input  logic [31:0]               i_rf_rs2,
    output logic [31:0]               o_op1,
    output logic [31:0]               o_op2
);

    localparam int RW = `RFIDX_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [RW-1:0] fifo_idx_q [FIFO_DEPTH];
    logic [RW-1:0] fifo_idx_d [FIFO_DEPTH];
    logic [31:0]   fifo_rd_q  [FIFO_DEPTH];
    logic [31:0]   fifo_rd_d  [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   pending_q, pending_d;

    logic          rden_q, rden_d;
    logic [RW-1:0] rdidx_q, rdidx_d;
    logic [31:0]   rd_q, rd_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          alu_xfer;
    logic          enq;
    logic          deq;
    logic [RW-1:0] head_idx;
    logic [31:0]   head_rd;
    logic          hz_pend;
    logic          hz_fwd;

    // Ready depends only on the pre-dequeue count, so a full FIFO never enqueues.
    always_comb begin
        fifo_full    = (cnt_q == CW'(FIFO_DEPTH));
        fifo_empty   = (cnt_q == '0);
        o_alu_ready  = !fifo_full;
        o_long_ready = !fifo_full;
        alu_xfer     = i_alu_valid && !fifo_full;
        enq          = i_long_valid && !fifo_full;
        deq          = !fifo_empty && (fifo_full || !alu_xfer);
        head_idx     = fifo_idx_q[rptr_q];
        head_rd      = fifo_rd_q[rptr_q];
    end

    always_comb begin
        rden_d  = 1'b0;
        rdidx_d = '0;
        rd_d    = '0;
        if (alu_xfer) begin
            rden_d  = (i_alu_rdidx != '0);
            rdidx_d = i_alu_rdidx;
            rd_d    = i_alu_rd;
        end else if (deq) begin
            rden_d  = (head_idx != '0);
            rdidx_d = head_idx;
            rd_d    = head_rd;
        end
    end

    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_rd_d  = fifo_rd_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        if (enq) begin
            fifo_idx_d[wptr_q] = i_long_rdidx;
            fifo_rd_d[wptr_q]  = i_long_rd;
            wptr_d             = wptr_q + PW'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Set is applied after clear so a same-cycle redispatch keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (deq) begin
            pending_d[head_idx] = 1'b0;
        end
        if (i_disp_valid && i_disp_long && (i_disp_rdidx != '0)) begin
            pending_d[i_disp_rdidx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        hz_pend = (i_chk_rs1en && (i_chk_rs1idx != '0) && pending_q[i_chk_rs1idx])
               || (i_chk_rs2en && (i_chk_rs2idx != '0) && pending_q[i_chk_rs2idx])
               || (i_chk_rden  && (i_chk_rdidx  != '0) && pending_q[i_chk_rdidx]);
`ifdef WBCK_BYPASS_EN
        hz_fwd = 1'b0;
        o_op1  = (rden_q && (rdidx_q == i_chk_rs1idx) && (i_chk_rs1idx != '0)) ? rd_q : i_rf_rs1;
        o_op2  = (rden_q && (rdidx_q == i_chk_rs2idx) && (i_chk_rs2idx != '0)) ? rd_q : i_rf_rs2;
`else
        // Without forwarding, a reader of the register being written waits one cycle for the commit.
        hz_fwd = (i_chk_rs1en && (i_chk_rs1idx != '0) && rden_q && (rdidx_q == i_chk_rs1idx))
              || (i_chk_rs2en && (i_chk_rs2idx != '0) && rden_q && (rdidx_q == i_chk_rs2idx));
        o_op1  = i_rf_rs1;
        o_op2  = i_rf_rs2;
`endif
        o_stall = hz_pend || hz_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_q[i] <= '0;
                fifo_rd_q[i]  <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            rden_q    <= 1'b0;
            rdidx_q   <= '0;
            rd_q      <= '0;
        end else begin
            fifo_idx_q <= fifo_idx_d;
            fifo_rd_q  <= fifo_rd_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            rden_q     <= rden_d;
            rdidx_q    <= rdidx_d;
            rd_q       <= rd_d;
        end
    end

    assign o_rden  = rden_q;
    assign o_rdidx = rdidx_q;
    assign o_rd    = rd_q;

endmodule

// File: tb/tb_regfile_wbck.sv
// Self-checking bench for regfile_wbck: directed scenarios then randomized traffic,
// compared against a queue-based model of the write-back rules.

module tb_regfile_wbck;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_alu_valid, o_alu_ready;
    logic [4:0]  i_alu_rdidx;
    logic [31:0] i_alu_rd;
    logic        i_long_valid, o_long_ready;
    logic [4:0]  i_long_rdidx;
    logic [31:0] i_long_rd;
    logic        o_rden;
    logic [4:0]  o_rdidx;
    logic [31:0] o_rd;
    logic        i_disp_valid, i_disp_long;
    logic [4:0]  i_disp_rdidx;
    logic        i_chk_rs1en, i_chk_rs2en, i_chk_rden;
    logic [4:0]  i_chk_rs1idx, i_chk_rs2idx, i_chk_rdidx;
    logic        o_stall;
    logic [31:0] i_rf_rs1, i_rf_rs2, o_op1, o_op2;

    regfile_wbck #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rdidx(i_alu_rdidx), .i_alu_rd(i_alu_rd),
        .i_long_valid(i_long_valid), .o_long_ready(o_long_ready),
        .i_long_rdidx(i_long_rdidx), .i_long_rd(i_long_rd),
        .o_rden(o_rden), .o_rdidx(o_rdidx), .o_rd(o_rd),
        .i_disp_valid(i_disp_valid), .i_disp_long(i_disp_long), .i_disp_rdidx(i_disp_rdidx),
        .i_chk_rs1en(i_chk_rs1en), .i_chk_rs2en(i_chk_rs2en), .i_chk_rden(i_chk_rden),
        .i_chk_rs1idx(i_chk_rs1idx), .i_chk_rs2idx(i_chk_rs2idx), .i_chk_rdidx(i_chk_rdidx),
        .o_stall(o_stall),
        .i_rf_rs1(i_rf_rs1), .i_rf_rs2(i_rf_rs2), .o_op1(o_op1), .o_op2(o_op2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as queues, pending as a plain bit vector, last write slot.
    logic [4:0]  q_idx[$];
    logic [31:0] q_dat[$];
    logic [31:0] m_pend = '0;
    logic        m_rden = 1'b0;
    logic [4:0]  m_rdidx = '0;
    logic [31:0] m_rd = '0;
    bit          last_alu_acc = 1'b0;
    bit          last_long_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        i_alu_valid = 0; i_alu_rdidx = 0; i_alu_rd = 0;
        i_long_valid = 0; i_long_rdidx = 0; i_long_rd = 0;
        i_disp_valid = 0; i_disp_long = 0; i_disp_rdidx = 0;
        i_chk_rs1en = 0; i_chk_rs2en = 0; i_chk_rden = 0;
        i_chk_rs1idx = 0; i_chk_rs2idx = 0; i_chk_rdidx = 0;
        i_rf_rs1 = 0; i_rf_rs2 = 0;
    endtask

    task automatic model_flush();
        q_idx.delete();
        q_dat.delete();
        m_pend = '0;
        m_rden = 1'b0;
        m_rdidx = '0;
        m_rd = '0;
    endtask

    task automatic check_comb();
        bit          full;
        bit          st;
        logic [31:0] e1, e2;
        full = (q_idx.size() == DEPTH);
        st = 1'b0;
        if (i_chk_rs1en && i_chk_rs1idx != 0 && m_pend[i_chk_rs1idx]) st = 1'b1;
        if (i_chk_rs2en && i_chk_rs2idx != 0 && m_pend[i_chk_rs2idx]) st = 1'b1;
        if (i_chk_rden  && i_chk_rdidx  != 0 && m_pend[i_chk_rdidx])  st = 1'b1;
        e1 = i_rf_rs1;
        e2 = i_rf_rs2;
`ifdef WBCK_BYPASS_EN
        if (m_rden && m_rdidx == i_chk_rs1idx && i_chk_rs1idx != 0) e1 = m_rd;
        if (m_rden && m_rdidx == i_chk_rs2idx && i_chk_rs2idx != 0) e2 = m_rd;
`else
        if (i_chk_rs1en && i_chk_rs1idx != 0 && m_rden && m_rdidx == i_chk_rs1idx) st = 1'b1;
        if (i_chk_rs2en && i_chk_rs2idx != 0 && m_rden && m_rdidx == i_chk_rs2idx) st = 1'b1;
`endif
        chk("long_ready", 32'(o_long_ready), 32'(!full));
        chk("alu_ready", 32'(o_alu_ready), 32'(!full));
        chk("stall", 32'(o_stall), 32'(st));
        chk("op1", o_op1, e1);
        chk("op2", o_op2, e2);
    endtask

    task automatic model_step();
        bit          full;
        logic [4:0]  hidx;
        logic [31:0] hdat;
        full = (q_idx.size() == DEPTH);
        last_alu_acc  = i_alu_valid && !full;
        last_long_acc = i_long_valid && !full;
        m_rden = 1'b0; m_rdidx = '0; m_rd = '0;
        if (last_alu_acc) begin
            m_rden = (i_alu_rdidx != 0); m_rdidx = i_alu_rdidx; m_rd = i_alu_rd;
        end else if (q_idx.size() > 0) begin
            hidx = q_idx.pop_front();
            hdat = q_dat.pop_front();
            m_pend[hidx] = 1'b0;
            m_rden = (hidx != 0); m_rdidx = hidx; m_rd = hdat;
        end
        if (last_long_acc) begin
            q_idx.push_back(i_long_rdidx);
            q_dat.push_back(i_long_rd);
        end
        if (i_disp_valid && i_disp_long && i_disp_rdidx != 0) m_pend[i_disp_rdidx] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; returns on the next falling edge.
    task automatic cycle();
        #1;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        chk("rden", 32'(o_rden), 32'(m_rden));
        if (m_rden) begin
            chk("rdidx", 32'(o_rdidx), 32'(m_rdidx));
            chk("rd", o_rd, m_rd);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        set_idle();
        rst_n = 1'b0;
        i_chk_rs1en = 1; i_chk_rs1idx = 5'd7;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rden", 32'(o_rden), 32'd0);
        chk("rst_rdidx", 32'(o_rdidx), 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_long_ready", 32'(o_long_ready), 32'd1);
        chk("rst_alu_ready", 32'(o_alu_ready), 32'd1);
        chk("rst_stall", 32'(o_stall), 32'd0);
        rst_n = 1'b1;
        model_flush();
        set_idle();
        @(negedge clk);

        // ALU-only write
        i_alu_valid = 1; i_alu_rdidx = 5'd5; i_alu_rd = 32'hDEADBEEF;
        cycle();
        chk("alu_rden", 32'(o_rden), 32'd1);
        chk("alu_rdidx", 32'(o_rdidx), 32'd5);
        chk("alu_rd", o_rd, 32'hDEADBEEF);
        i_alu_valid = 0;

        // Long write with scoreboard on r7
        i_disp_valid = 1; i_disp_long = 1; i_disp_rdidx = 5'd7;
        cycle();
        i_disp_valid = 0; i_disp_long = 0;
        i_chk_rs1en = 1; i_chk_rs1idx = 5'd7;
        #1 chk("r7_stall_set", 32'(o_stall), 32'd1);
        i_long_valid = 1; i_long_rdidx = 5'd7; i_long_rd = 32'h1234;
        cycle();
        i_long_valid = 0;
        cycle();
        chk("r7_rden", 32'(o_rden), 32'd1);
        chk("r7_rdidx", 32'(o_rdidx), 32'd7);
        chk("r7_rd", o_rd, 32'h1234);
        cycle();
        #1 chk("r7_stall_clear", 32'(o_stall), 32'd0);
        i_chk_rs1en = 0;

        // Back-pressure: ALU busy every cycle while three long results arrive
        sent = 0;
        i_alu_valid = 1; i_alu_rdidx = 5'd1; i_alu_rd = $urandom;
        for (int c = 0; c < 40 && sent < 3; c++) begin
            i_long_valid = 1; i_long_rdidx = 5'(20 + sent); i_long_rd = 32'h1000 + 32'(sent);
            cycle();
            if (last_long_acc) begin
                sent++;
                if (sent == 2) begin
                    #1;
                    chk("bp_long_ready_full", 32'(o_long_ready), 32'd0);
                    chk("bp_alu_ready_full", 32'(o_alu_ready), 32'd0);
                end
            end
            if (last_alu_acc) begin
                i_alu_rdidx = 5'(c % 30 + 1); i_alu_rd = $urandom;
            end
        end
        chk("bp_all_sent", 32'(sent), 32'd3);
        i_alu_valid = 0; i_long_valid = 0;
        repeat (4) cycle();

        // Writes to x0 are consumed but never reach the register file
        i_alu_valid = 1; i_alu_rdidx = 0; i_alu_rd = 32'hFFFF0000;
        i_long_valid = 1; i_long_rdidx = 0; i_long_rd = 32'h0000FFFF;
        repeat (3) cycle();
        i_alu_valid = 0; i_long_valid = 0;
        repeat (4) cycle();
        chk("x0_rden", 32'(o_rden), 32'd0);
        #1 chk("x0_fifo_empty", 32'(o_long_ready), 32'd1);
        @(negedge clk);

        // Set/clear collision on r9
        i_disp_valid = 1; i_disp_long = 1; i_disp_rdidx = 5'd9;
        cycle();
        i_disp_valid = 0;
        i_long_valid = 1; i_long_rdidx = 5'd9; i_long_rd = 32'h99;
        cycle();
        i_long_valid = 0;
        i_disp_valid = 1;
        cycle();
        i_disp_valid = 0; i_disp_long = 0;
        i_chk_rs1en = 1; i_chk_rs1idx = 5'd9;
        repeat (2) cycle();
        #1 chk("collide_stall", 32'(o_stall), 32'd1);
        i_long_valid = 1; i_long_rd = 32'h100;
        cycle();
        i_long_valid = 0;
        repeat (3) cycle();
        i_chk_rs1en = 0;

        // Forwarding of the in-flight write
        i_alu_valid = 1; i_alu_rdidx = 5'd3; i_alu_rd = 32'hA5A5A5A5;
        cycle();
        i_alu_valid = 0;
        i_chk_rs1en = 1; i_chk_rs1idx = 5'd3; i_rf_rs1 = 32'h0;
        #1;
`ifdef WBCK_BYPASS_EN
        chk("byp_op1", o_op1, 32'hA5A5A5A5);
        chk("byp_stall", 32'(o_stall), 32'd0);
`else
        chk("nobyp_op1", o_op1, 32'h0);
        chk("nobyp_stall", 32'(o_stall), 32'd1);
`endif
        cycle();
        #1 chk("byp_stall_after", 32'(o_stall), 32'd0);
        i_chk_rs1en = 0;
        @(negedge clk);

        // Reset with a full FIFO and pending bits
        i_disp_valid = 1; i_disp_long = 1; i_disp_rdidx = 5'd10;
        cycle();
        i_disp_rdidx = 5'd11;
        cycle();
        i_disp_valid = 0; i_disp_long = 0;
        i_alu_valid = 1; i_alu_rdidx = 5'd4; i_alu_rd = 32'h44;
        i_long_valid = 1; i_long_rdidx = 5'd10; i_long_rd = 32'hA0;
        cycle();
        i_long_rdidx = 5'd11; i_long_rd = 32'hB0;
        cycle();
        i_alu_valid = 0; i_long_valid = 0;
        i_chk_rs1en = 1; i_chk_rs1idx = 5'd10;
        rst_n = 1'b0;
        #1;
        chk("mrst_rden", 32'(o_rden), 32'd0);
        chk("mrst_rdidx", 32'(o_rdidx), 32'd0);
        chk("mrst_rd", o_rd, 32'd0);
        chk("mrst_long_ready", 32'(o_long_ready), 32'd1);
        chk("mrst_alu_ready", 32'(o_alu_ready), 32'd1);
        chk("mrst_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_flush();
        repeat (5) cycle();
        i_chk_rs1en = 0;

        // Randomized traffic with valid/payload held until accepted
        set_idle();
        last_alu_acc = 1'b0;
        last_long_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!i_alu_valid || last_alu_acc) begin
                i_alu_valid = ($urandom_range(0, 2) == 0);
                i_alu_rdidx = 5'($urandom_range(0, 7));
                i_alu_rd    = $urandom;
            end
            if (!i_long_valid || last_long_acc) begin
                i_long_valid = ($urandom_range(0, 1) == 0);
                i_long_rdidx = 5'($urandom_range(0, 7));
                i_long_rd    = $urandom;
            end
            i_disp_valid = ($urandom_range(0, 2) == 0);
            i_disp_long  = $urandom_range(0, 1) == 1;
            i_disp_rdidx = 5'($urandom_range(0, 7));
            i_chk_rs1en  = $urandom_range(0, 1) == 1;
            i_chk_rs2en  = $urandom_range(0, 1) == 1;
            i_chk_rden   = $urandom_range(0, 1) == 1;
            i_chk_rs1idx = 5'($urandom_range(0, 7));
            i_chk_rs2idx = 5'($urandom_range(0, 7));
            i_chk_rdidx  = 5'($urandom_range(0, 7));
            i_rf_rs1     = $urandom;
            i_rf_rs2     = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
